cmdpkt_tx: RTL and testbench

Transmit-side generator for the switch command packet. On each accepted command it builds a fixed 60-byte Ethernet/IPv4/UDP frame carrying the magic word and four forwarding-port bytes. It writes the frame into a TX-FIFO in the same 9-bit word format the lookup side consumes: bit 8 is the in-frame flag and bits 7:0 are the data byte. Each frame is followed by a delimiter word so the receiving parser's byte counter realigns.

---
 rtl/cmdpkt_tx.sv | 176 +++++++++++++++++
 tb/tb_cmdpkt_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmdpkt_tx.sv
// +----------------------------------------------------------------------------+
// | cmdpkt_tx : builds the 60-byte Ethernet/IPv4/UDP switch command frame and  |
// |             streams it as {in_frame, byte} words plus a delimiter word.    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module cmdpkt_tx #(
  parameter logic [47:0] SRC_MAC      = 48'h00_11_22_33_44_55,
  parameter logic [47:0] DST_MAC      = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP       = 32'h0A000001,
  parameter logic [31:0] DST_IP       = 32'h0A000002,
  parameter logic [15:0] UDP_SRC_PORT = 16'd3776,
  parameter logic [15:0] UDP_DST_PORT = 16'd3776,
  parameter logic [31:0] MAGIC        = 32'hC0C0C0CC
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_port,
  output logic        cmd_ready,
  output logic [8:0]  tx_din,
  output logic        tx_wr_en,
  input  logic        tx_full,
  output logic        busy,
  output logic [15:0] frame_id
);

  localparam int unsigned c_FRAME_BYTES = 60;
  localparam int unsigned c_FRAME_BITS  = c_FRAME_BYTES * 8;
  localparam logic [5:0]  c_LAST_IDX    = 6'(c_FRAME_BYTES - 1);
  localparam logic [15:0] c_ETHERTYPE   = 16'h0800;
  localparam logic [15:0] c_IP_VER_TOS  = 16'h4500;
  localparam logic [15:0] c_IP_TOT_LEN  = 16'h0024;
  localparam logic [15:0] c_IP_FRAG     = 16'h0000;
  localparam logic [7:0]  c_IP_TTL      = 8'h40;
  localparam logic [7:0]  c_IP_PROTO    = 8'h11;
  localparam logic [15:0] c_UDP_LEN     = 16'h0010;
  localparam logic [15:0] c_UDP_CSUM    = 16'h0000;
  localparam logic [8:0]  c_DELIM       = 9'h000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CSUM1 = 3'd2,
    ST_CSUM2 = 3'd3,
    ST_SEND  = 3'd4,
    ST_DELIM = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  logic [31:0] r_ports, w_ports_nxt;
  logic [15:0] r_frame_id, w_frame_id_nxt;
  logic [19:0] r_sum, w_sum_nxt;
  logic [15:0] r_csum, w_csum_nxt;
  logic [8:0]  r_tx_din, w_tx_din_nxt;
  logic        r_tx_wr_en, w_tx_wr_en_nxt;

  logic [19:0] w_hdr_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [c_FRAME_BITS-1:0] w_frame;
  logic [c_FRAME_BITS-1:0] w_frame_shifted;
  logic [7:0]  w_byte;

  // IPv4 header halfwords with the checksum field taken as zero
  assign w_hdr_sum = {4'd0, c_IP_VER_TOS} + {4'd0, c_IP_TOT_LEN} + {4'd0, r_frame_id}
                   + {4'd0, c_IP_FRAG} + {4'd0, c_IP_TTL, c_IP_PROTO}
                   + {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]}
                   + {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};

  assign w_fold1 = {1'b0, r_sum[15:0]} + {13'd0, r_sum[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'd0, w_fold1[16]};

  // Whole frame laid out MSB-first; byte 0 sits in the top eight bits
  assign w_frame = {DST_MAC, SRC_MAC, c_ETHERTYPE,
                    c_IP_VER_TOS, c_IP_TOT_LEN, r_frame_id, c_IP_FRAG,
                    c_IP_TTL, c_IP_PROTO, r_csum, SRC_IP, DST_IP,
                    UDP_SRC_PORT, UDP_DST_PORT, c_UDP_LEN, c_UDP_CSUM,
                    MAGIC,
                    r_ports[7:0], r_ports[15:8], r_ports[23:16], r_ports[31:24],
                    80'd0};

  assign w_frame_shifted = w_frame << {r_idx, 3'b000};
  assign w_byte          = w_frame_shifted[c_FRAME_BITS-1 -: 8];

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_ports_nxt    = r_ports;
    w_frame_id_nxt = r_frame_id;
    w_sum_nxt      = r_sum;
    w_csum_nxt     = r_csum;
    w_tx_din_nxt   = r_tx_din;
    w_tx_wr_en_nxt = 1'b0;

    case (r_state)
      ST_INIT: begin
        // Flush any partial frame left downstream by a mid-frame reset
        if (!tx_full) begin
          w_tx_wr_en_nxt = 1'b1;
          w_tx_din_nxt   = c_DELIM;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          w_ports_nxt = cmd_port;
          w_state_nxt = ST_CSUM1;
        end
      end
      ST_CSUM1: begin
        w_sum_nxt   = w_hdr_sum;
        w_state_nxt = ST_CSUM2;
      end
      ST_CSUM2: begin
        w_csum_nxt  = ~w_fold2;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_full) begin
          w_tx_wr_en_nxt = 1'b1;
          w_tx_din_nxt   = {1'b1, w_byte};
          w_idx_nxt      = r_idx + 6'd1;
          if (r_idx == c_LAST_IDX) begin
            w_state_nxt = ST_DELIM;
          end
        end
      end
      ST_DELIM: begin
        if (!tx_full) begin
          w_tx_wr_en_nxt = 1'b1;
          w_tx_din_nxt   = c_DELIM;
          w_frame_id_nxt = r_frame_id + 16'd1;
          w_idx_nxt      = 6'd0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_INIT;
      r_idx      <= 6'd0;
      r_ports    <= 32'd0;
      r_frame_id <= 16'd0;
      r_sum      <= 20'd0;
      r_csum     <= 16'd0;
      r_tx_din   <= 9'h000;
      r_tx_wr_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_ports    <= w_ports_nxt;
      r_frame_id <= w_frame_id_nxt;
      r_sum      <= w_sum_nxt;
      r_csum     <= w_csum_nxt;
      r_tx_din   <= w_tx_din_nxt;
      r_tx_wr_en <= w_tx_wr_en_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign tx_din    = r_tx_din;
  assign tx_wr_en  = r_tx_wr_en;
  assign frame_id  = r_frame_id;

endmodule

`default_nettype wire

// File: tb/tb_cmdpkt_tx.sv
// +----------------------------------------------------------------------------+
// | tb_cmdpkt_tx : scoreboard bench for cmdpkt_tx command frame generator      |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cmdpkt_tx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic [31:0] cmd_port;
  logic        cmd_ready;
  logic [8:0]  tx_din;
  logic        tx_wr_en;
  logic        tx_full;
  logic        busy;
  logic [15:0] frame_id;

  cmdpkt_tx dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_port  (cmd_port),
    .cmd_ready (cmd_ready),
    .tx_din    (tx_din),
    .tx_wr_en  (tx_wr_en),
    .tx_full   (tx_full),
    .busy      (busy),
    .frame_id  (frame_id)
  );

  always #5 sys_clk = ~sys_clk;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  logic [8:0]  sb_q[$];
  logic [7:0]  cap[0:59];
  int          cap_idx  = 0;
  int          wr_cnt   = 0;
  int          acc_cnt  = 0;
  int          cyc      = 0;
  int          acc_cyc[$];
  logic [15:0] model_fid = 16'd0;

  typedef struct {
    logic [31:0] port;
    logic [31:0] port_bytes;
    logic [15:0] fid;
    logic [15:0] csum;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] fid);
    logic [31:0] s;
    s = 32'h4500 + 32'h0024 + {16'd0, fid} + 32'h4011 + 32'h0A00 + 32'h0001 + 32'h0A00 + 32'h0002;
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic push_frame(input logic [15:0] fid, input logic [31:0] port);
    logic [7:0]  f[60];
    logic [15:0] cs;
    for (int i = 0; i < 60; i++) f[i] = 8'h00;
    for (int i = 0; i < 6; i++) f[i] = 8'hFF;
    f[6] = 8'h00; f[7] = 8'h11; f[8] = 8'h22; f[9] = 8'h33; f[10] = 8'h44; f[11] = 8'h55;
    f[12] = 8'h08; f[14] = 8'h45; f[17] = 8'h24;
    f[18] = fid[15:8]; f[19] = fid[7:0];
    f[22] = 8'h40; f[23] = 8'h11;
    cs = model_csum(fid);
    f[24] = cs[15:8]; f[25] = cs[7:0];
    f[26] = 8'h0A; f[29] = 8'h01; f[30] = 8'h0A; f[33] = 8'h02;
    f[34] = 8'h0E; f[35] = 8'hC0; f[36] = 8'h0E; f[37] = 8'hC0;
    f[39] = 8'h10;
    f[42] = 8'hC0; f[43] = 8'hC0; f[44] = 8'hC0; f[45] = 8'hCC;
    f[46] = port[7:0]; f[47] = port[15:8]; f[48] = port[23:16]; f[49] = port[31:24];
    for (int i = 0; i < 60; i++) sb_q.push_back({1'b1, f[i]});
    sb_q.push_back(9'h000);
  endtask

  // Mid-cycle sampling: pop on every write, record accepts due at the next edge
  always @(negedge sys_clk) begin
    cyc++;
    if (tx_wr_en) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL sb_unexpected_write: got %h, expected no write", tx_din);
      end else begin
        check("sb_word", {23'd0, tx_din}, {23'd0, sb_q.pop_front()});
      end
      if (tx_din[8]) begin
        if (cap_idx < 60) cap[cap_idx] = tx_din[7:0];
        cap_idx++;
      end else begin
        cap_idx = 0;
      end
    end
    if (sys_rst_n && cmd_valid && cmd_ready) begin
      push_frame(model_fid, cmd_port);
      model_fid++;
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge sys_clk); #1;
      n++;
    end while (!cmd_ready && n < 300);
    check("idle_reached", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic send_cmd(input logic [31:0] p);
    int t;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    check("ready_for_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_port  = p;
    cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   start;
    int   t;

    vecs[0] = '{32'h0B0A0908, 32'h08090A0B, 16'h0000, 16'h66C7};
    vecs[1] = '{32'hDEADBEEF, 32'hEFBEADDE, 16'h0001, 16'h66C6};
    vecs[2] = '{32'h00000000, 32'h00000000, 16'h0002, 16'h66C5};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0003, 16'h66C4};

    sys_rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_port  = 32'd0;
    tx_full   = 1'b0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_wr_en",     {31'd0, tx_wr_en},  32'd0);
    check("rst_din",       {23'd0, tx_din},    32'd0);
    check("rst_busy",      {31'd0, busy},      32'd1);
    check("rst_frame_id",  {16'd0, frame_id},  32'd0);

    // Exactly one INIT delimiter, then a quiet idle
    sb_q.push_back(9'h000);
    sys_rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    check("init_write_count", wr_cnt, 32'd1);
    check("init_sb_left",     sb_q.size(), 32'd0);
    check("idle_cmd_ready",   {31'd0, cmd_ready}, 32'd1);
    check("idle_busy",        {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_cmd(vecs[i].port);
      wait_idle(n);
      check("frame_latency", n, 32'd63);
      repeat (2) @(posedge sys_clk);
      #1;
      check("frame_id_bytes", {16'd0, cap[18], cap[19]}, {16'd0, vecs[i].fid});
      check("checksum_bytes", {16'd0, cap[24], cap[25]}, {16'd0, vecs[i].csum});
      check("magic_bytes",    {cap[42], cap[43], cap[44], cap[45]}, 32'hC0C0C0CC);
      check("port_bytes",     {cap[46], cap[47], cap[48], cap[49]}, vecs[i].port_bytes);
      check("frame_id_after", {16'd0, frame_id}, {16'd0, vecs[i].fid + 16'd1});
      check("frame_sb_left",  sb_q.size(), 32'd0);
    end

    // Stall 5 cycles on byte 0x17 and 3 cycles on the delimiter
    send_cmd(32'h04030201);
    fork
      wait_idle(n);
      begin
        repeat (25) @(posedge sys_clk);
        #1 tx_full = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1 tx_full = 1'b0;
        repeat (37) @(posedge sys_clk);
        #1 tx_full = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 tx_full = 1'b0;
      end
    join
    check("stall_latency", n, 32'd71);
    repeat (2) @(posedge sys_clk);
    #1;
    check("stall_sb_left", sb_q.size(), 32'd0);

    // Reset in the middle of the frame, while byte 0x20 is on the bus
    send_cmd(32'h11223344);
    repeat (35) @(posedge sys_clk);
    #2;
    check("pre_rst_wr_en", {31'd0, tx_wr_en}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", {31'd0, tx_wr_en}, 32'd0);
    check("async_rst_busy",  {31'd0, busy}, 32'd1);
    check("async_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_words_unsent", sb_q.size(), 32'd29);
    sb_q.delete();
    cap_idx   = 0;
    model_fid = 16'd0;
    sb_q.push_back(9'h000);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("post_rst_init_sb", sb_q.size(), 32'd0);
    send_cmd(32'h0B0A0908);
    wait_idle(n);
    repeat (2) @(posedge sys_clk);
    #1;
    check("post_rst_fid_bytes", {16'd0, cap[18], cap[19]}, 32'd0);
    check("post_rst_csum",      {16'd0, cap[24], cap[25]}, 32'h66C7);
    check("post_rst_frame_id",  {16'd0, frame_id}, 32'd1);
    check("post_rst_sb_left",   sb_q.size(), 32'd0);

    // cmd_valid held high: three back-to-back frames
    start     = acc_cnt;
    cmd_port  = 32'hA5A55A5A;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(posedge sys_clk); #1;
      t++;
    end while (acc_cnt < start + 3 && t < 400);
    cmd_valid = 1'b0;
    check("b2b_accepts", acc_cnt - start, 32'd3);
    wait_idle(n);
    repeat (2) @(posedge sys_clk);
    #1;
    for (int i = start + 1; i < acc_cnt; i++)
      check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32'd64);
    check("b2b_frame_id", {16'd0, frame_id}, {16'd0, model_fid});
    check("b2b_sb_left",  sb_q.size(), 32'd0);

    // Preload frame_id to FFFF to exercise the wrap
    force dut.r_frame_id = 16'hFFFF;
    #1;
    release dut.r_frame_id;
    model_fid = 16'hFFFF;
    check("preload_frame_id", {16'd0, frame_id}, 32'h0000FFFF);
    send_cmd(32'h0D0C0B0A);
    wait_idle(n);
    repeat (2) @(posedge sys_clk);
    #1;
    check("wrap_fid_bytes", {16'd0, cap[18], cap[19]}, 32'h0000FFFF);
    check("wrap_csum",      {16'd0, cap[24], cap[25]}, 32'h66C7);
    check("wrap_frame_id",  {16'd0, frame_id}, 32'd0);
    check("final_sb_left",  sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
